// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption engine: one Feistel round per clock, 16 rounds per block.
// Bit numbering follows DES: index 0 of every vector is DES bit 1 (the MSB).
// The key schedule starts from C0/D0 (== C16/D16) and rotates right after each
// round, so that subkeys are produced in decryption order K16..K1.
module des_decrypt_iter #(
    parameter int CHECK_PARITY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [0:63] key,
    input  logic [0:63] cipherText,
    output logic        busy,
    output logic        done,
    output logic [0:63] plainText,
    output logic        key_err
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

    // Each S-box is 64 nibbles, row-major (row 0 col 0 first), leftmost nibble = entry 0.
    localparam logic [0:255] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [0:63] ip_perm(input logic [0:63] x);
        logic [0:63] y;
        for (int i = 0; i < 64; i++) y[i] = x[6'(IP_T[i] - 1)];
        return y;
    endfunction

    function automatic logic [0:63] fp_perm(input logic [0:63] x);
        logic [0:63] y;
        for (int i = 0; i < 64; i++) y[i] = x[6'(FP_T[i] - 1)];
        return y;
    endfunction

    function automatic logic [0:55] pc1_perm(input logic [0:63] k);
        logic [0:55] y;
        for (int i = 0; i < 56; i++) y[i] = k[6'(PC1_T[i] - 1)];
        return y;
    endfunction

    function automatic logic [0:47] pc2_perm(input logic [0:55] cd);
        logic [0:47] y;
        for (int i = 0; i < 48; i++) y[i] = cd[6'(PC2_T[i] - 1)];
        return y;
    endfunction

    // Right rotation undoes the encryption-side left shift of the same round.
    function automatic logic [0:27] rotr(input logic [0:27] x, input logic by_one);
        return by_one ? {x[27], x[0:26]} : {x[26:27], x[0:25]};
    endfunction

    function automatic logic [0:31] feistel(input logic [0:31] rr, input logic [0:47] k);
        logic [0:47] ex;
        logic [0:31] sv;
        logic [0:31] y;
        logic [5:0]  b;
        logic [5:0]  idx;
        for (int i = 0; i < 48; i++) ex[i] = rr[5'(E_T[i] - 1)];
        ex = ex ^ k;
        for (int s = 0; s < 8; s++) begin
            b   = ex[6*s +: 6];                  // b[5] is the first DES bit of the group
            idx = {b[5], b[0], b[4:1]};          // row = outer bits, column = inner bits
            sv[4*s +: 4] = SBOX[s][{idx, 2'b00} +: 4];
        end
        for (int i = 0; i < 32; i++) y[i] = sv[5'(P_T[i] - 1)];
        return y;
    endfunction

    // True when any key byte has even parity (DES expects odd parity per byte).
    function automatic logic parity_bad(input logic [0:63] k);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 8; i++)
            if (^k[8*i +: 8] == 1'b0) bad = 1'b1;
        return bad;
    endfunction

    state_t      state;
    logic [4:0]  rnd;
    logic [0:31] l, r;
    logic [0:27] c, d;
    logic [0:47] subkey;
    logic [0:31] fout;
    logic        shift_one;

    // Round function for the current round from the live L/R/C/D state.
    always_comb begin
        subkey    = pc2_perm({c, d});
        fout      = feistel(r, subkey);
        shift_one = (rnd == 5'd1) || (rnd == 5'd8) || (rnd == 5'd15) || (rnd == 5'd16);
    end

    // Control FSM plus round datapath; outputs are all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rnd       <= 5'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            plainText <= 64'h0;
            key_err   <= 1'b0;
            l         <= 32'h0;
            r         <= 32'h0;
            c         <= 28'h0;
            d         <= 28'h0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        {l, r}  <= ip_perm(cipherText);
                        {c, d}  <= pc1_perm(key);
                        rnd     <= 5'd1;
                        busy    <= 1'b1;
                        key_err <= (CHECK_PARITY != 0) && parity_bad(key);
                        state   <= ROUND;
                    end else begin
                        state <= IDLE;
                    end
                end
                ROUND: begin
                    l <= r;
                    r <= l ^ fout;
                    c <= rotr(c, shift_one);
                    d <= rotr(d, shift_one);
                    if (rnd == 5'd16) begin
                        // Final swap: preoutput is {R16, L16} = {L15 ^ f, R15}.
                        plainText <= fp_perm({l ^ fout, r});
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        rnd       <= 5'd0;
                        state     <= DONE;
                    end else begin
                        rnd <= rnd + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Bench for des_decrypt_iter: published DES vectors plus an encryption-direction
// reference model used to build loopback ciphertexts.
module tb_des_decrypt_iter;

    localparam int IPT [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FPT [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int PC1T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8,
        16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int ET [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int PT [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int SB [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,  0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,  15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,  3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,  13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,  13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,  1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,  13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,  3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,  14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,  11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,  10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,  4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,  13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,  6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,  1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,  2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    localparam logic [63:0] STD_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] STD_CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] STD_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] ZERO_CT = 64'h8CA64DE9C1B123A7;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [63:0] key, ct;
    logic        busy1, done1, kerr1, busy0, done0, kerr0;
    logic [63:0] pt1, pt0;
    int          ncmp = 0;
    int          nerr = 0;

    typedef struct {
        logic [63:0] k;
        logic [63:0] c;
        logic [63:0] p;
        logic        ke;
    } vec_t;
    vec_t vt [8];

    des_decrypt_iter #(.CHECK_PARITY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .cipherText(ct),
        .busy(busy1), .done(done1), .plainText(pt1), .key_err(kerr1));

    des_decrypt_iter #(.CHECK_PARITY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .cipherText(ct),
        .busy(busy0), .done(done0), .plainText(pt0), .key_err(kerr0));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Straightforward DES encryption (left-shift key schedule, subkeys K1..K16).
    function automatic logic [63:0] model_enc(input logic [63:0] kin, input logic [63:0] pin);
        logic [0:63] k, x, y;
        logic [0:55] cd;
        logic [0:27] c, d;
        logic [0:47] ks [16];
        logic [0:47] e;
        logic [0:31] l, r, s32, f, tmp;
        int          row, col, sh;
        k = kin;
        x = pin;
        for (int i = 0; i < 56; i++) cd[i] = k[6'(PC1T[i] - 1)];
        c = cd[0:27];
        d = cd[28:55];
        for (int n = 0; n < 16; n++) begin
            sh = (n == 0 || n == 1 || n == 8 || n == 15) ? 1 : 2;
            for (int m = 0; m < sh; m++) begin
                c = {c[1:27], c[0]};
                d = {d[1:27], d[0]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[n][i] = cd[6'(PC2T[i] - 1)];
        end
        for (int i = 0; i < 64; i++) y[i] = x[6'(IPT[i] - 1)];
        l = y[0:31];
        r = y[32:63];
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 48; i++) e[i] = r[5'(ET[i] - 1)];
            e = e ^ ks[n];
            for (int s = 0; s < 8; s++) begin
                row = 2 * int'(e[6*s]) + int'(e[6*s+5]);
                col = int'(e[6*s+1 +: 4]);
                s32[4*s +: 4] = 4'(SB[s][16*row + col]);
            end
            for (int i = 0; i < 32; i++) f[i] = s32[5'(PT[i] - 1)];
            tmp = r;
            r   = l ^ f;
            l   = tmp;
        end
        x = {r, l};
        for (int i = 0; i < 64; i++) y[i] = x[6'(FPT[i] - 1)];
        return y;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Apply one block from IDLE and check latency, result and flags.
    task automatic run_block(input int id, input logic [63:0] k, input logic [63:0] c,
                             input logic [63:0] p, input logic ke);
        int   cyc;
        logic gap;
        @(posedge clk); #1;
        key = k; ct = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        key = ~k; ct = {$urandom, $urandom};
        chk($sformatf("v%0d_busy_e0", id), busy1, 1);
        cyc = 0;
        gap = 1'b0;
        while (!done1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (!done1 && !busy1) gap = 1'b1;
        end
        chk($sformatf("v%0d_latency", id), cyc, 16);
        chk($sformatf("v%0d_busy_gap", id), gap, 0);
        chk($sformatf("v%0d_busy_done", id), busy1, 0);
        chk($sformatf("v%0d_pt", id), pt1, p);
        chk($sformatf("v%0d_kerr_par1", id), kerr1, ke);
        chk($sformatf("v%0d_pt_par0", id), pt0, p);
        chk($sformatf("v%0d_kerr_par0", id), kerr0, 0);
        chk($sformatf("v%0d_done_par0", id), done0, 1);
        @(posedge clk); #1;
        chk($sformatf("v%0d_done_drop", id), done1, 0);
        chk($sformatf("v%0d_pt_hold", id), pt1, p);
    endtask

    initial begin
        int   cyc;
        int   ndone;
        logic stable;

        rst_n = 1'b0; start = 1'b0; key = 64'h0; ct = 64'h0;

        // Reference model against published vectors.
        chk("model_std",  model_enc(STD_KEY, STD_PT), STD_CT);
        chk("model_zero", model_enc(64'h0, 64'h0), ZERO_CT);
        chk("model_now",  model_enc(64'h0123456789ABCDEF, 64'h4E6F772069732074), 64'h3FA40E8A984D4815);
        chk("model_0e32", model_enc(64'h0E329232EA6D0D73, 64'h8787878787878787), 64'h0);

        vt[0] = '{STD_KEY, STD_CT, STD_PT, 1'b0};
        vt[1] = '{64'h0, ZERO_CT, 64'h0, 1'b1};
        vt[2] = '{64'h3030303030303030, model_enc(64'h3030303030303030, 64'h3132333435363738),
                  64'h3132333435363738, 1'b1};
        vt[3] = '{64'h0E329232EA6D0D73, 64'h0, 64'h8787878787878787, 1'b0};
        vt[4] = '{64'h0123456789ABCDEF, 64'h3FA40E8A984D4815, 64'h4E6F772069732074, 1'b0};
        vt[5] = '{64'h0123456789ABCDEE, model_enc(64'h0123456789ABCDEE, 64'hA5A5F00FC3C31234),
                  64'hA5A5F00FC3C31234, 1'b1};
        vt[6] = '{64'h0023456789ABCDEF, model_enc(64'h0023456789ABCDEF, 64'hFEDCBA9876543210),
                  64'hFEDCBA9876543210, 1'b1};
        vt[7] = '{64'hFEFEFEFEFEFEFEFE, model_enc(64'hFEFEFEFEFEFEFEFE, 64'h5555AAAA3333CCCC),
                  64'h5555AAAA3333CCCC, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_pt", pt1, 64'h0);
        chk("rst_kerr", kerr1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_block(i, vt[i].k, vt[i].c, vt[i].p, vt[i].ke);

        // Reset in the middle of a run.
        @(posedge clk); #1;
        key = STD_KEY; ct = STD_CT; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy1, 0);
        chk("midrst_done", done1, 0);
        chk("midrst_pt", pt1, 64'h0);
        chk("midrst_kerr", kerr1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done1) ndone++;
        end
        chk("midrst_no_done", ndone, 0);

        // Start while busy is ignored.
        @(posedge clk); #1;
        key = STD_KEY; ct = STD_CT; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        key = 64'h0; ct = ZERO_CT; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 7;
        while (!done1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("busy_start_latency", cyc, 16);
        chk("busy_start_pt", pt1, STD_PT);
        chk("busy_start_kerr", kerr1, 0);
        ndone = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done1) ndone++;
        end
        chk("busy_start_extra_done", ndone, 0);

        // Back-to-back: second start held in the DONE cycle.
        @(posedge clk); #1;
        key = STD_KEY; ct = STD_CT; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b2b_first_latency", cyc, 16);
        chk("b2b_first_pt", pt1, STD_PT);
        key = 64'h0; ct = ZERO_CT; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        stable = 1'b1;
        if (pt1 !== STD_PT) stable = 1'b0;
        while (!done1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (!done1 && pt1 !== STD_PT) stable = 1'b0;
        end
        chk("b2b_spacing", cyc, 17);
        chk("b2b_pt_stable", stable, 1);
        chk("b2b_second_pt", pt1, 64'h0);
        chk("b2b_second_kerr", kerr1, 1);
        @(posedge clk); #1;
        chk("b2b_done_drop", done1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/des_decrypt_iter.md
Name: des_decrypt_iter

Overview:
- Iterative DES decryption engine, one Feistel round per clock. It is the inverse direction of the existing combinational encryption top (mode/key/plainText/encrypted).
- Accepts a 64-bit ciphertext and key on a start pulse and produces the 64-bit plaintext 16 cycles later.
- Sits beside the encryptor so encrypted data can be recovered in loopback and in system use.
- Uses DES bit numbering: index 0 = DES bit 1, the MSB.

Parameters:
- CHECK_PARITY, 0, 1 = check the odd parity of each key byte at start and report the result on key_err; 0 = key_err tied low.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only when busy=0.
- key  input  [0:63]  64-bit DES key including parity bits; sampled with start.
- cipherText  input  [0:63]  block to decrypt; sampled with start.
- busy  output  1  high while rounds are in progress.
- done  output  1  one-cycle pulse when plainText is valid.
- plainText  output  [0:63]  decrypted block, held until the next completion.
- key_err  output  1  parity flag for the last accepted key, held until the next accept.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE, round counter to 0.
  - busy=0, done=0, plainText=64'h0, key_err=0; internal L/R/C/D registers cleared.
- State machine:
  - IDLE -> ROUND on start=1.
  - ROUND -> DONE after round 16.
  - DONE -> IDLE after one cycle.
  - DONE -> ROUND directly if start=1 in the DONE cycle (back-to-back operation).
- Accept edge E0 (start=1 while IDLE or DONE):
  - {L,R} <= IP(cipherText).
  - {C,D} <= PC1(key), 28 bits each.
  - rnd <= 1, busy <= 1, key_err <= (CHECK_PARITY && any key byte with even popcount).
- start while busy=1 is ignored; no queueing.
- Round edges E1..E16, round i uses subkey K(17-i) = PC2(C,D) of the current C/D:
  - L <= R; R <= L ^ f(R, K).
  - f = E-expansion, XOR with the 48-bit subkey, S1..S8 lookup, P-permutation.
  - After computing K, C and D are each rotated RIGHT by the encryption shift of round 17-i.
  - Shift amount is 1 for encryption rounds 1, 2, 9, 16 and 2 otherwise; i=16 rotates by 1, restoring C0/D0.
  - No rotation is applied before round 1, because C16 = C0.
- E16:
  - plainText <= FP({R,L}) (final swap, then inverse IP).
  - done <= 1, busy <= 0, state DONE.
- E17: done <= 0 unless another completion occurs; plainText is held.
- Latency: done is high in the cycle after E16. That is 16 clocks from accept, with a throughput of one block per 17 clocks.
- Inputs key and cipherText may change freely after E0 without affecting the result.
- Reset asserted mid-operation aborts immediately; no done pulse is produced and plainText returns to 0.
- S-boxes are 64x4-bit constant tables indexed by {b0,b5} for the row and b1..b4 for the column, per FIPS 46-3.
- All permutation tables match FIPS 46-3 exactly.
- Purely synchronous datapath aside from the reset; no combinational path from inputs to outputs.

Test Plan:
- Reset mid-run: start, assert rst_n=0 at E5 -> busy=0, done=0 and plainText=0 immediately; no done pulse follows.
- Standard vector: key=64'h133457799BBCDFF1, cipherText=64'h85E813540F0AB405, start at E0 -> done high only for the cycle after E16, plainText=64'h0123456789ABCDEF, busy high E0..E16, key_err=0.
- Zero vector: key=0, cipherText=64'h8CA64DE9C1B123A7, CHECK_PARITY=1 -> plainText=64'h0, key_err=1 (all bytes have even parity).
- Loopback: encrypt key=64'h3030303030303030, plainText=64'h3132333435363738 through the encryption top, feed the result here -> plainText=64'h3132333435363738; key_err=1 when CHECK_PARITY=1, 0 when CHECK_PARITY=0.
- Start while busy: second start at E7 with different data -> ignored; result equals the first block, exactly one done pulse.
- Back-to-back: start held high in the DONE cycle with the zero vector after the standard vector -> two done pulses exactly 17 cycles apart with correct plaintexts; plainText is stable between the pulses.
